dvp_pixel_framer: RTL and testbench
===================================

Name: dvp_pixel_framer

Overview:
- Sits between the camera DVP input pins (already in the pixel-clock domain) and the column/row integer counters.
- Assembles `BYTES_PER_PIXEL` bytes into pixels and tracks frame/line state from vsync/href.
- Emits the per-pixel enable and the line/frame clear pulses that drive the downstream counters.
- Checks line length and frame height against expected geometry and flags mismatches.

Parameters:
- `BYTES_PER_PIXEL`, 2, bytes per pixel (1..4).
- `EXPECTED_WIDTH`, 640, pixels per line.
- `EXPECTED_HEIGHT`, 480, lines per frame.
- `VSYNC_ACTIVE_HIGH`, 1, 1: vsync high = blanking; 0: inverted.

Ports:
- `clock`  in  1  pixel clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cam_vsync`  in  1  frame sync, polarity per `VSYNC_ACTIVE_HIGH`.
- `cam_href`  in  1  line valid, active high.
- `cam_data`  in  8  pixel byte.
- `pixel_valid`  out  1  one-cycle pulse, `pixel_data` valid; drives column counter enable.
- `pixel_data`  out  8*BYTES_PER_PIXEL  assembled pixel, first byte in MSBs.
- `line_start`  out  1  one-cycle pulse; drives column counter clear.
- `line_end`  out  1  one-cycle pulse; drives row counter enable.
- `frame_start`  out  1  one-cycle pulse; drives row counter clear.
- `in_frame`  out  1  high while in a synchronised frame's active region.
- `line_error`  out  1  one-cycle pulse, bad line length.
- `frame_error`  out  1  one-cycle pulse, bad line count.

Behaviour:
- Reset: asynchronous, active-high; all outputs 0, `pixel_data` 0, state `SYNC_WAIT`, byte phase 0, counts 0.
- Internal `vs` = `cam_vsync` XOR NOT `VSYNC_ACTIVE_HIGH` (`vs`=1 means blanking).
- All outputs registered: each reflects the inputs sampled on the previous rising edge (latency 1).
- FSM states:
  - `SYNC_WAIT`: ignore everything until `vs`=1, then go to `VBLANK`. Discards the partial frame seen after reset.
  - `VBLANK`: on `vs`=0, go to `ACTIVE`; pulse `frame_start`; clear line count; set `in_frame`.
  - `ACTIVE`: `href`=1 with `vs`=0 goes to `LINE`, pulses `line_start`, clears pixel count and byte phase, and captures the byte as phase 0.
  - `LINE`: each cycle with `href`=1, shift the byte into the pixel shift register and advance the phase. When the phase wraps from `BYTES_PER_PIXEL`-1 to 0:
    - pulse `pixel_valid` with the completed word;
    - increment pixel count, saturating at `EXPECTED_WIDTH`+1.
  - `LINE`, `href` falling: pulse `line_end`; increment line count, saturating at `EXPECTED_HEIGHT`+1.
    - Pulse `line_error` in the same cycle if pixel count ≠ `EXPECTED_WIDTH` or byte phase ≠ 0. The partial pixel is dropped.
    - Return to `ACTIVE`.
  - `vs`=1 from `ACTIVE` or `LINE`:
    - if in `LINE`, perform the `line_end` handling first in the same cycle;
    - pulse `frame_error` if the final line count ≠ `EXPECTED_HEIGHT`;
    - clear `in_frame`; go to `VBLANK`.
- `href` in `VBLANK` or `SYNC_WAIT`: ignored, no pulses.
- Simultaneous `line_end` and `frame_error` are allowed in one cycle. `line_start` and `frame_start` are never in the same cycle (they need distinct state visits).
- Back-to-back lines (`href` low for 1 cycle) must be handled with no lost pulses.
- `BYTES_PER_PIXEL`=1: `pixel_valid` mirrors the sampled `href` during `LINE`.
- Count widths: `$clog2(EXPECTED_WIDTH+2)` and `$clog2(EXPECTED_HEIGHT+2)`.
- Reset mid-line: immediate return to `SYNC_WAIT`; no pulses until the next full vsync blanking.

Optional Feature:
- Macro `DVP_FRAME_STATS_EN`.
- Defined:
  - adds outputs `meas_width` (`$clog2(EXPECTED_WIDTH+2)` bits), latched from pixel count at every `line_end`;
  - adds outputs `meas_height` (`$clog2(EXPECTED_HEIGHT+2)` bits), latched from line count at every `VBLANK` entry from `ACTIVE`/`LINE`;
  - adds `frames_dropped` (16 bits), incremented with wrap on every `frame_error`;
  - all three reset to 0.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

Test Plan (`BYTES_PER_PIXEL`=2, `EXPECTED_WIDTH`=4, `EXPECTED_HEIGHT`=3):
- Reset, vsync pulse, 3 lines of 8 bytes 0x01..0x08 → `frame_start` once; per line 4 `pixel_valid` with `pixel_data` 0x0102, 0x0304, 0x0506, 0x0708; `line_start`/`line_end` ×3; no errors.
- Line of 7 bytes → `line_end` plus `line_error` in the same cycle; 3 `pixel_valid`; partial byte dropped; next line clean.
- Only 2 lines, then vsync → `frame_error` pulse when vsync asserts; `in_frame` falls the same cycle.
- Data with `href` and vsync low immediately after reset (no prior vsync) → zero outputs until the first vsync-blank-then-active cycle.
- Async reset asserted mid-line after 3 bytes → outputs 0 immediately (no clock edge needed); no `pixel_valid` resumes until the next full frame.
- `DVP_FRAME_STATS_EN` defined, line of 10 bytes → `meas_width`=5, `line_error`=1; frame of 4 lines → `meas_height`=4, `frames_dropped`=1.

Source files
------------

// File: rtl/dvp_pixel_framer.sv
// ---------------------------------------------------------------------------
// dvp_pixel_framer
//
// Camera DVP front end in the pixel-clock domain. It assembles BYTES_PER_PIXEL
// bytes into one pixel and follows frame and line state from vsync and href.
// It produces the enable and clear pulses for the downstream column and row
// counters. It also checks line length and frame height against the expected
// geometry.
//
// Ports:
//   clock        in   pixel clock, rising edge
//   reset        in   asynchronous, active-high
//   cam_vsync    in   frame sync; polarity set by VSYNC_ACTIVE_HIGH
//   cam_href     in   line valid, active high
//   cam_data     in   pixel byte
//   pixel_valid  out  one-cycle pulse, pixel_data valid (column counter enable)
//   pixel_data   out  assembled pixel, first byte in the MSBs
//   line_start   out  one-cycle pulse (column counter clear)
//   line_end     out  one-cycle pulse (row counter enable)
//   frame_start  out  one-cycle pulse (row counter clear)
//   in_frame     out  high inside a synchronised frame's active region
//   line_error   out  one-cycle pulse, line length differs from EXPECTED_WIDTH
//   frame_error  out  one-cycle pulse, line count differs from EXPECTED_HEIGHT
//
// Optional build macro DVP_FRAME_STATS_EN adds these outputs:
//   meas_width      pixel count latched at every line_end
//   meas_height     line count latched on every return to vertical blanking
//   frames_dropped  wrapping count of frame_error pulses
//
// Every output is registered. Each output reflects the inputs sampled on the
// previous rising edge.
// ---------------------------------------------------------------------------
module dvp_pixel_framer #(
   parameter int BYTES_PER_PIXEL   = 2,
   parameter int EXPECTED_WIDTH    = 640,
   parameter int EXPECTED_HEIGHT   = 480,
   parameter int VSYNC_ACTIVE_HIGH = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           cam_vsync,
   input  logic                           cam_href,
   input  logic [7:0]                     cam_data,
   output logic                           pixel_valid,
   output logic [8*BYTES_PER_PIXEL-1:0]   pixel_data,
   output logic                           line_start,
   output logic                           line_end,
   output logic                           frame_start,
   output logic                           in_frame,
   output logic                           line_error,
   output logic                           frame_error
`ifdef DVP_FRAME_STATS_EN
   ,
   output logic [$clog2(EXPECTED_WIDTH+2)-1:0]  meas_width,
   output logic [$clog2(EXPECTED_HEIGHT+2)-1:0] meas_height,
   output logic [15:0]                          frames_dropped
`endif
);

   localparam int PIX_W = 8 * BYTES_PER_PIXEL;
   // The shift register holds the bytes already received for the current
   // pixel. The 1-byte case keeps a dummy byte so the widths stay legal.
   localparam int SH_W  = (BYTES_PER_PIXEL > 1) ? PIX_W - 8 : 8;
   localparam int PH_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam int CW_W  = $clog2(EXPECTED_WIDTH + 2);
   localparam int CW_H  = $clog2(EXPECTED_HEIGHT + 2);

   localparam logic [CW_W-1:0] W_EXP  = CW_W'(EXPECTED_WIDTH);
   localparam logic [CW_W-1:0] W_SAT  = CW_W'(EXPECTED_WIDTH + 1);
   localparam logic [CW_H-1:0] H_EXP  = CW_H'(EXPECTED_HEIGHT);
   localparam logic [CW_H-1:0] H_SAT  = CW_H'(EXPECTED_HEIGHT + 1);
   localparam logic [PH_W-1:0] PH_END = PH_W'(BYTES_PER_PIXEL - 1);

   typedef enum logic [1:0] {SYNC_WAIT, VBLANK, ACTIVE, LINE} state_t;

   function automatic logic [CW_W-1:0] sat_inc_w(input logic [CW_W-1:0] v);
      return (v >= W_SAT) ? W_SAT : v + CW_W'(1);
   endfunction

   function automatic logic [CW_H-1:0] sat_inc_h(input logic [CW_H-1:0] v);
      return (v >= H_SAT) ? H_SAT : v + CW_H'(1);
   endfunction

   state_t            state_q;
   logic [PH_W-1:0]   phase_q;
   logic [SH_W-1:0]   shift_q;
   logic [CW_W-1:0]   pix_cnt_q;
   logic [CW_H-1:0]   line_cnt_q;
   logic              pixel_valid_q, line_start_q, line_end_q, frame_start_q;
   logic              in_frame_q, line_error_q, frame_error_q;
   logic [PIX_W-1:0]  pixel_data_q;
`ifdef DVP_FRAME_STATS_EN
   logic [CW_W-1:0]   meas_width_q;
   logic [CW_H-1:0]   meas_height_q;
   logic [15:0]       frames_dropped_q;
`endif

   // vs = 1 means vertical blanking, whatever the pin polarity is
   logic              vs;
   logic [SH_W+7:0]   shift_ext;
   logic [PIX_W-1:0]  word_d;
   logic [SH_W-1:0]   shift_d;
   logic [CW_W-1:0]   pix_cnt_d;
   logic [CW_H-1:0]   line_cnt_d;
   logic              line_bad;

   assign vs         = (VSYNC_ACTIVE_HIGH != 0) ? cam_vsync : ~cam_vsync;
   assign shift_ext  = {shift_q, cam_data};
   assign word_d     = shift_ext[PIX_W-1:0];
   assign shift_d    = shift_ext[SH_W-1:0];
   assign pix_cnt_d  = sat_inc_w(pix_cnt_q);
   assign line_cnt_d = sat_inc_h(line_cnt_q);
   // A trailing partial pixel also makes the line bad; that pixel is dropped.
   assign line_bad   = (pix_cnt_q != W_EXP) || (phase_q != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= SYNC_WAIT;
         phase_q          <= '0;
         shift_q          <= '0;
         pix_cnt_q        <= '0;
         line_cnt_q       <= '0;
         pixel_valid_q    <= 1'b0;
         pixel_data_q     <= '0;
         line_start_q     <= 1'b0;
         line_end_q       <= 1'b0;
         frame_start_q    <= 1'b0;
         in_frame_q       <= 1'b0;
         line_error_q     <= 1'b0;
         frame_error_q    <= 1'b0;
`ifdef DVP_FRAME_STATS_EN
         meas_width_q     <= '0;
         meas_height_q    <= '0;
         frames_dropped_q <= '0;
`endif
      end else begin
         pixel_valid_q <= 1'b0;
         line_start_q  <= 1'b0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
         line_error_q  <= 1'b0;
         frame_error_q <= 1'b0;
         case (state_q)
            // Wait for blanking so that the partial frame after reset is dropped
            SYNC_WAIT: begin
               if (vs) state_q <= VBLANK;
            end
            VBLANK: begin
               if (!vs) begin
                  state_q       <= ACTIVE;
                  frame_start_q <= 1'b1;
                  line_cnt_q    <= '0;
                  in_frame_q    <= 1'b1;
               end
            end
            ACTIVE: begin
               if (vs) begin
                  frame_error_q <= (line_cnt_q != H_EXP);
                  in_frame_q    <= 1'b0;
                  state_q       <= VBLANK;
`ifdef DVP_FRAME_STATS_EN
                  meas_height_q <= line_cnt_q;
                  if (line_cnt_q != H_EXP) frames_dropped_q <= frames_dropped_q + 16'd1;
`endif
               end else if (cam_href) begin
                  // The first byte of the line is captured as phase 0. With one
                  // byte per pixel it completes a pixel immediately.
                  state_q      <= LINE;
                  line_start_q <= 1'b1;
                  shift_q      <= shift_d;
                  if (BYTES_PER_PIXEL == 1) begin
                     phase_q       <= '0;
                     pixel_valid_q <= 1'b1;
                     pixel_data_q  <= word_d;
                     pix_cnt_q     <= CW_W'(1);
                  end else begin
                     phase_q   <= PH_W'(1);
                     pix_cnt_q <= '0;
                  end
               end
            end
            LINE: begin
               if (vs || !cam_href) begin
                  // Line end handling also runs when vsync cuts off a line
                  line_end_q   <= 1'b1;
                  line_error_q <= line_bad;
                  line_cnt_q   <= line_cnt_d;
`ifdef DVP_FRAME_STATS_EN
                  meas_width_q <= pix_cnt_q;
`endif
                  if (vs) begin
                     frame_error_q <= (line_cnt_d != H_EXP);
                     in_frame_q    <= 1'b0;
                     state_q       <= VBLANK;
`ifdef DVP_FRAME_STATS_EN
                     meas_height_q <= line_cnt_d;
                     if (line_cnt_d != H_EXP) frames_dropped_q <= frames_dropped_q + 16'd1;
`endif
                  end else begin
                     state_q <= ACTIVE;
                  end
               end else begin
                  shift_q <= shift_d;
                  if (phase_q == PH_END) begin
                     phase_q       <= '0;
                     pixel_valid_q <= 1'b1;
                     pixel_data_q  <= word_d;
                     pix_cnt_q     <= pix_cnt_d;
                  end else begin
                     phase_q <= phase_q + PH_W'(1);
                  end
               end
            end
            default: state_q <= SYNC_WAIT;
         endcase
      end
   end

   assign pixel_valid = pixel_valid_q;
   assign pixel_data  = pixel_data_q;
   assign line_start  = line_start_q;
   assign line_end    = line_end_q;
   assign frame_start = frame_start_q;
   assign in_frame    = in_frame_q;
   assign line_error  = line_error_q;
   assign frame_error = frame_error_q;
`ifdef DVP_FRAME_STATS_EN
   assign meas_width     = meas_width_q;
   assign meas_height    = meas_height_q;
   assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: tb/tb_dvp_pixel_framer.sv
// ---------------------------------------------------------------------------
// Testbench for dvp_pixel_framer with BYTES_PER_PIXEL=2, EXPECTED_WIDTH=4 and
// EXPECTED_HEIGHT=3.
//
// The stimulus is built from frame-level segments: vertical blanking, a lead-in
// gap, and lines of N bytes followed by a gap. Each segment task writes the
// expected outputs for every cycle from the frame/line rules into a queue.
// One compare process checks the DUT against that queue on every cycle.
// ---------------------------------------------------------------------------
module tb_dvp_pixel_framer;
   localparam int BPP = 2;
   localparam int W   = 4;
   localparam int H   = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cam_vsync = 1'b0;
   logic        cam_href  = 1'b0;
   logic [7:0]  cam_data  = 8'h00;
   logic        pixel_valid, line_start, line_end, frame_start, in_frame;
   logic        line_error, frame_error;
   logic [15:0] pixel_data;
`ifdef DVP_FRAME_STATS_EN
   logic [2:0]  meas_width, meas_height;
   logic [15:0] frames_dropped;
`endif

   dvp_pixel_framer #(
      .BYTES_PER_PIXEL(BPP), .EXPECTED_WIDTH(W), .EXPECTED_HEIGHT(H), .VSYNC_ACTIVE_HIGH(1)
   ) dut (
      .clock(clock), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
      .line_start(line_start), .line_end(line_end), .frame_start(frame_start),
      .in_frame(in_frame), .line_error(line_error), .frame_error(frame_error)
`ifdef DVP_FRAME_STATS_EN
      , .meas_width(meas_width), .meas_height(meas_height), .frames_dropped(frames_dropped)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        vs, href;
      logic [7:0]  data;
      logic        pv, ls, le, fs, inf, lerr, ferr;
      logic [15:0] pd;
      int          mw, mh, fd;
   } rec_t;

   rec_t q[$];
   rec_t cur;
   bit   chk_on = 1'b0;
   int   n_err = 0, n_checks = 0;
   int   n_fs = 0, n_pv = 0, n_ls = 0, n_le = 0, n_lerr = 0, n_ferr = 0;
   logic [15:0] obs_pix[$];

   // frame-level model state
   bit          m_synced, m_inframe;
   int          m_lines, m_pend, m_mw, m_mh, m_fd;
   logic [15:0] m_pd;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_synced = 0; m_inframe = 0; m_lines = 0; m_pend = -1;
      m_mw = 0; m_mh = 0; m_fd = 0; m_pd = 16'h0000;
   endtask

   function automatic rec_t new_rec(input logic vs, input logic href, input logic [7:0] d);
      rec_t r;
      r.vs = vs; r.href = href; r.data = d;
      r.pv = 0; r.ls = 0; r.le = 0; r.fs = 0; r.inf = 0; r.lerr = 0; r.ferr = 0;
      r.pd = 16'h0000; r.mw = 0; r.mh = 0; r.fd = 0;
      return r;
   endfunction

   task automatic push(input rec_t r_in);
      rec_t r = r_in;
      r.pd = m_pd; r.inf = m_inframe; r.mw = m_mw; r.mh = m_mh; r.fd = m_fd;
      q.push_back(r);
   endtask

   // A line that is still open when it ends (by href falling or by vsync)
   task automatic close_line(inout rec_t r);
      r.le = 1; r.lerr = (m_pend != W * BPP);
      m_lines++; m_mw = imin(m_pend / BPP, W + 1); m_pend = -1;
   endtask

   task automatic seg_vblank(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         r = new_rec(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
         if (i == 0 && m_inframe) begin
            if (m_pend >= 0) close_line(r);
            r.ferr = (m_lines != H);
            m_mh = imin(m_lines, H + 1);
            if (m_lines != H) m_fd++;
            m_inframe = 0;
         end
         m_pend = -1; m_synced = 1;
         push(r);
      end
   endtask

   task automatic seg_lead(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         r = new_rec(1'b0, 1'b0, 8'($urandom));
         if (i == 0 && m_synced && !m_inframe) begin
            r.fs = 1; m_inframe = 1; m_lines = 0;
         end
         push(r);
      end
   endtask

   task automatic seg_line(input int len, input int gap, input bit directed);
      rec_t r;
      logic [7:0] d, prev;
      prev = 8'h00;
      for (int k = 0; k < len; k++) begin
         d = directed ? 8'(k + 1) : 8'($urandom);
         r = new_rec(1'b0, 1'b1, d);
         if (m_inframe) begin
            if (k == 0) r.ls = 1;
            if (k % BPP == BPP - 1) begin r.pv = 1; m_pd = {prev, d}; end
         end
         prev = d;
         push(r);
      end
      if (m_inframe) m_pend = len;
      for (int g = 0; g < gap; g++) begin
         r = new_rec(1'b0, 1'b0, 8'($urandom));
         if (g == 0 && m_pend >= 0) close_line(r);
         push(r);
      end
   endtask

   task automatic run_queue();
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clock);
         cam_vsync = r.vs; cam_href = r.href; cam_data = r.data;
         cur = r; chk_on = 1'b1;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
      check({tag, "_pixel_data"},  32'(pixel_data),  0);
      check({tag, "_line_start"},  32'(line_start),  0);
      check({tag, "_line_end"},    32'(line_end),    0);
      check({tag, "_frame_start"}, 32'(frame_start), 0);
      check({tag, "_in_frame"},    32'(in_frame),    0);
      check({tag, "_line_error"},  32'(line_error),  0);
      check({tag, "_frame_error"}, 32'(frame_error), 0);
   endtask

   // Per-cycle compare against the model queue
   always @(posedge clock) begin
      if (chk_on) begin
         #1;
         check("pixel_valid", 32'(pixel_valid), 32'(cur.pv));
         check("pixel_data",  32'(pixel_data),  32'(cur.pd));
         check("line_start",  32'(line_start),  32'(cur.ls));
         check("line_end",    32'(line_end),    32'(cur.le));
         check("frame_start", 32'(frame_start), 32'(cur.fs));
         check("in_frame",    32'(in_frame),    32'(cur.inf));
         check("line_error",  32'(line_error),  32'(cur.lerr));
         check("frame_error", 32'(frame_error), 32'(cur.ferr));
`ifdef DVP_FRAME_STATS_EN
         check("meas_width",     32'(meas_width),     32'(cur.mw));
         check("meas_height",    32'(meas_height),    32'(cur.mh));
         check("frames_dropped", 32'(frames_dropped), 32'(cur.fd));
`endif
         if (frame_start === 1'b1) n_fs++;
         if (line_start  === 1'b1) n_ls++;
         if (line_end    === 1'b1) n_le++;
         if (line_error  === 1'b1) n_lerr++;
         if (frame_error === 1'b1) n_ferr++;
         if (pixel_valid === 1'b1) begin n_pv++; obs_pix.push_back(pixel_data); end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs0, pv0, ls0, le0, lerr0, ferr0, nl, len, gap;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      // Bytes with vsync low before any blanking are ignored
      pv0 = n_pv; ls0 = n_ls;
      seg_lead(2); seg_line(8, 1, 1); seg_line(6, 2, 0);
      run_queue();
      @(posedge clock); #2;
      check("unsynced_pv_count", 32'(n_pv - pv0), 0);
      check("unsynced_ls_count", 32'(n_ls - ls0), 0);

      // Clean frame: 3 lines of bytes 01..08
      fs0 = n_fs; pv0 = n_pv; ls0 = n_ls; le0 = n_le; lerr0 = n_lerr; ferr0 = n_ferr;
      obs_pix.delete();
      seg_vblank(3); seg_lead(2);
      for (int l = 0; l < 3; l++) seg_line(8, 2, 1);
      seg_vblank(3);
      run_queue();
      @(posedge clock); #2;
      check("clean_fs_count",   32'(n_fs - fs0), 1);
      check("clean_pv_count",   32'(n_pv - pv0), 12);
      check("clean_ls_count",   32'(n_ls - ls0), 3);
      check("clean_le_count",   32'(n_le - le0), 3);
      check("clean_lerr_count", 32'(n_lerr - lerr0), 0);
      check("clean_ferr_count", 32'(n_ferr - ferr0), 0);
      check("clean_pix0", 32'(obs_pix[0]), 32'h0102);
      check("clean_pix1", 32'(obs_pix[1]), 32'h0304);
      check("clean_pix2", 32'(obs_pix[2]), 32'h0506);
      check("clean_pix3", 32'(obs_pix[3]), 32'h0708);

      // A 7-byte line in the middle of the frame; its odd byte is dropped
      pv0 = n_pv; le0 = n_le; lerr0 = n_lerr; ferr0 = n_ferr;
      seg_lead(1); seg_line(8, 1, 1); seg_line(7, 1, 1); seg_line(8, 1, 1); seg_vblank(2);
      run_queue();
      @(posedge clock); #2;
      check("short_pv_count",   32'(n_pv - pv0), 11);
      check("short_le_count",   32'(n_le - le0), 3);
      check("short_lerr_count", 32'(n_lerr - lerr0), 1);
      check("short_ferr_count", 32'(n_ferr - ferr0), 0);
      check("short_pix_total",  32'(obs_pix.size()), 23);
      check("short_line_pix3",  32'(obs_pix[18]), 32'h0506);
      check("next_line_pix1",   32'(obs_pix[19]), 32'h0102);

      // Two-line frame; vsync cuts off the second line
      le0 = n_le; ferr0 = n_ferr;
      seg_lead(1); seg_line(8, 1, 1); seg_line(8, 0, 1); seg_vblank(2);
      run_queue();
      @(posedge clock); #2;
      check("two_line_ferr_count", 32'(n_ferr - ferr0), 1);
      check("two_line_le_count",   32'(n_le - le0), 2);

      // Random frames: mixed line lengths, one-cycle gaps, lines cut by vsync
      for (int f = 0; f < 30; f++) begin
         seg_lead($urandom_range(1, 3));
         nl = $urandom_range(0, 5);
         for (int l = 0; l < nl; l++) begin
            len = ($urandom_range(0, 9) < 6) ? 8 : $urandom_range(1, 11);
            gap = (l == nl - 1 && $urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            seg_line(len, gap, 1'b0);
         end
         seg_vblank($urandom_range(1, 4));
      end
      run_queue();

      // Asynchronous reset three bytes into a line
      seg_lead(1); seg_line(3, 0, 1);
      run_queue();
      @(posedge clock); #2;
      check("preres_in_frame",   32'(in_frame),   1);
      check("preres_pixel_data", 32'(pixel_data), 32'h0102);
      #1;
      chk_on = 1'b0;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // Line continues after reset: no pulses until a full blanking period
      pv0 = n_pv; lerr0 = n_lerr;
      seg_line(5, 1, 0); seg_lead(2); seg_vblank(2); seg_lead(1); seg_line(10, 1, 0);
      run_queue();
      @(posedge clock); #2;
      check("long_line_error", 32'(line_error), 1);
      check("post_reset_pv_count", 32'(n_pv - pv0), 5);
`ifdef DVP_FRAME_STATS_EN
      check("long_meas_width", 32'(meas_width), 5);
`endif
      ferr0 = n_ferr;
      seg_line(8, 1, 0); seg_line(8, 1, 0); seg_line(8, 0, 0); seg_vblank(2);
      run_queue();
      @(posedge clock); #2;
      check("four_line_ferr_count", 32'(n_ferr - ferr0), 1);
`ifdef DVP_FRAME_STATS_EN
      check("four_line_meas_height",    32'(meas_height),    4);
      check("four_line_frames_dropped", 32'(frames_dropped), 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
